traffic_phase_ctrl: RTL and testbench

Actuated intersection scheduler that sequences the NS/EW signal heads and a pedestrian walk phase. It generates its own phase tick from `clk` and arbitrates green time between the two vehicle approaches. It serves pedestrian requests between phases. It replaces the free-running fixed-time traffic light at the top of the intersection design.

---
 rtl/traffic_phase_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: actuated two-approach intersection scheduler with a pedestrian walk phase.
//
// Sequence: NS_G -> NS_Y -> ALL_RA -> [PED] -> EW_G -> EW_Y -> ALL_RB -> [PED] -> NS_G.
// Transitions are evaluated only on internal phase ticks (one every TICK_DIV clks).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ns_car, ew_car     vehicle presence per approach (sampled on tick clks)
//   ped_req            pedestrian button (pulse or level)
//   ns_g/ns_y/ns_r     NS signal head (registered)
//   ew_g/ew_y/ew_r     EW signal head (registered)
//   walk               pedestrian walk lamp (registered)
//   ped_ack            one-clk pulse on entry to the walk phase
//   tick               internal phase tick, for observation
//
// Configuration: define TRAFFIC_PED_EN to build the pedestrian logic. Without it the walk
// phase is unreachable, ped_req is ignored and walk/ped_ack are tied low.
module traffic_phase_ctrl #(
   parameter int unsigned TICK_DIV  = 5,
   parameter int unsigned GREEN_MIN = 5,
   parameter int unsigned GREEN_MAX = 10,
   parameter int unsigned YELLOW_T  = 2,
   parameter int unsigned ALLRED_T  = 1,
   parameter int unsigned WALK_T    = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ns_car,
   input  logic ew_car,
   input  logic ped_req,
   output logic ns_g,
   output logic ns_y,
   output logic ns_r,
   output logic ew_g,
   output logic ew_y,
   output logic ew_r,
   output logic walk,
   output logic ped_ack,
   output logic tick
);

   localparam int unsigned DW = $clog2(TICK_DIV);
   localparam int unsigned CW = $clog2(GREEN_MAX + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_SAT  = CW'(GREEN_MAX);

   localparam logic [2:0] StNsG  = 3'd0;
   localparam logic [2:0] StNsY  = 3'd1;
   localparam logic [2:0] StAllRa = 3'd2;
   localparam logic [2:0] StEwG  = 3'd3;
   localparam logic [2:0] StEwY  = 3'd4;
   localparam logic [2:0] StAllRb = 3'd5;
   localparam logic [2:0] StPed  = 3'd6;

   // Head lamp vector order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
   localparam logic [5:0] HeadsRst = 6'b100_001;

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [CW-1:0] phase_cnt_q, phase_cnt_d;
   logic [2:0]    state_q, state_d;
   logic          next_ew_q, next_ew_d;   // green to resume after the walk phase
   logic [5:0]    heads_q, heads_d;
   logic [31:0]   e;                      // ticks elapsed including the current one
   logic          ped_pend;

   assign tick = (div_cnt_q == DIV_LAST);
   assign e    = 32'(phase_cnt_q) + 32'd1;

   always_comb begin
      div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
   end

   always_comb begin
      state_d   = state_q;
      next_ew_d = next_ew_q;
      if (tick) begin
         case (state_q)
            StNsG: begin
               if (e >= GREEN_MIN && (ew_car || ped_pend) && (!ns_car || e >= GREEN_MAX)) begin
                  state_d = StNsY;
               end
            end
            StNsY: if (e == YELLOW_T) state_d = StAllRa;
            StAllRa: begin
               if (e == ALLRED_T) begin
                  if (ped_pend) begin
                     state_d   = StPed;
                     next_ew_d = 1'b1;
                  end else begin
                     state_d = StEwG;
                  end
               end
            end
            StEwG: begin
               if (e >= GREEN_MIN && (ns_car || ped_pend) && (!ew_car || e >= GREEN_MAX)) begin
                  state_d = StEwY;
               end
            end
            StEwY: if (e == YELLOW_T) state_d = StAllRb;
            StAllRb: begin
               if (e == ALLRED_T) begin
                  if (ped_pend) begin
                     state_d   = StPed;
                     next_ew_d = 1'b0;
                  end else begin
                     state_d = StNsG;
                  end
               end
            end
            StPed: if (e == WALK_T) state_d = next_ew_q ? StEwG : StNsG;
            default: state_d = StNsG;
         endcase
      end
   end

   // Counter restarts on any state change; saturation keeps it from wrapping while resting.
   always_comb begin
      if (state_d != state_q) begin
         phase_cnt_d = '0;
      end else if (tick && phase_cnt_q != CNT_SAT) begin
         phase_cnt_d = phase_cnt_q + CW'(1);
      end else begin
         phase_cnt_d = phase_cnt_q;
      end
   end

   // Lamps are decoded from the next state so they flip on the same edge as the state.
   always_comb begin
      case (state_d)
         StNsG:   heads_d = 6'b100_001;
         StNsY:   heads_d = 6'b010_001;
         StEwG:   heads_d = 6'b001_100;
         StEwY:   heads_d = 6'b001_010;
         default: heads_d = 6'b001_001;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q   <= '0;
         phase_cnt_q <= '0;
         state_q     <= StNsG;
         next_ew_q   <= 1'b0;
         heads_q     <= HeadsRst;
      end else begin
         div_cnt_q   <= div_cnt_d;
         phase_cnt_q <= phase_cnt_d;
         state_q     <= state_d;
         next_ew_q   <= next_ew_d;
         heads_q     <= heads_d;
      end
   end

   assign {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = heads_q;

`ifdef TRAFFIC_PED_EN
   logic enter_ped;
   logic ped_pending_q, ped_pending_d;
   logic ped_ack_q, ped_ack_d;
   logic walk_q, walk_d;

   assign enter_ped = (state_d == StPed) && (state_q != StPed);

   // Requests are ignored during the walk and on its entry clk, so they cannot re-arm it.
   always_comb begin
      if (enter_ped) begin
         ped_pending_d = 1'b0;
      end else if (state_q != StPed && ped_req) begin
         ped_pending_d = 1'b1;
      end else begin
         ped_pending_d = ped_pending_q;
      end
      ped_ack_d = enter_ped;
      walk_d    = (state_d == StPed);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ped_pending_q <= 1'b0;
         ped_ack_q     <= 1'b0;
         walk_q        <= 1'b0;
      end else begin
         ped_pending_q <= ped_pending_d;
         ped_ack_q     <= ped_ack_d;
         walk_q        <= walk_d;
      end
   end

   assign ped_pend = ped_pending_q;
   assign walk     = walk_q;
   assign ped_ack  = ped_ack_q;
`else
   logic unused_ped_req;
   assign unused_ped_req = ped_req;
   assign ped_pend       = 1'b0;
   assign walk           = 1'b0;
   assign ped_ack        = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios plus random car/button
// traffic, compared every clk against a phase-level reference model.
module tb_traffic_phase_ctrl;

   localparam int TD   = 4;
   localparam int GMIN = 3;
   localparam int GMAX = 6;
   localparam int YT   = 2;
   localparam int AT   = 1;
   localparam int WT   = 4;
`ifdef TRAFFIC_PED_EN
   localparam bit PE = 1'b1;
`else
   localparam bit PE = 1'b0;
`endif

   localparam int P_NSG = 0, P_NSY = 1, P_ARA = 2, P_EWG = 3, P_EWY = 4, P_ARB = 5, P_PED = 6;

   logic clk = 1'b0;
   logic rst_n;
   logic ns_car, ew_car, ped_req;
   logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_ack, tick;
   logic [6:0] lamps;

   assign lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk};

   traffic_phase_ctrl #(
      .TICK_DIV (TD),
      .GREEN_MIN(GMIN),
      .GREEN_MAX(GMAX),
      .YELLOW_T (YT),
      .ALLRED_T (AT),
      .WALK_T   (WT)
   ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ns_car (ns_car),
      .ew_car (ew_car),
      .ped_req(ped_req),
      .ns_g   (ns_g),
      .ns_y   (ns_y),
      .ns_r   (ns_r),
      .ew_g   (ew_g),
      .ew_y   (ew_y),
      .ew_r   (ew_r),
      .walk   (walk),
      .ped_ack(ped_ack),
      .tick   (tick)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: phase name, clks since reset, ticks spent in phase, pending button.
   int m_ph, m_k, m_ticks, m_after;
   bit m_pend, m_ack;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   function automatic logic [6:0] exp_lamps(input int ph);
      case (ph)
         P_NSG:   return 7'b100_001_0;
         P_NSY:   return 7'b010_001_0;
         P_EWG:   return 7'b001_100_0;
         P_EWY:   return 7'b001_010_0;
         P_PED:   return 7'b001_001_1;
         default: return 7'b001_001_0;
      endcase
   endfunction

   function automatic bit inv_ok(input logic [6:0] l);
      bit ns_one, ew_one;
      ns_one = ($countones(l[6:4]) == 1);
      ew_one = ($countones(l[3:1]) == 1);
      return ns_one && ew_one && (!l[0] || (l[4] && l[1]));
   endfunction

   // Advance the model over one rising edge using the inputs currently applied.
   task automatic model_edge();
      bit is_tick, was_ped;
      int nxt, e;
      is_tick = ((m_k % TD) == TD - 1);
      was_ped = (m_ph == P_PED);
      nxt     = m_ph;
      e       = m_ticks + 1;
      if (is_tick) begin
         case (m_ph)
            P_NSG: if (e >= GMIN && (ew_car || m_pend) && (!ns_car || e >= GMAX)) nxt = P_NSY;
            P_NSY: if (e == YT) nxt = P_ARA;
            P_ARA: if (e == AT) begin
               nxt = m_pend ? P_PED : P_EWG;
               if (m_pend) m_after = P_EWG;
            end
            P_EWG: if (e >= GMIN && (ns_car || m_pend) && (!ew_car || e >= GMAX)) nxt = P_EWY;
            P_EWY: if (e == YT) nxt = P_ARB;
            P_ARB: if (e == AT) begin
               nxt = m_pend ? P_PED : P_NSG;
               if (m_pend) m_after = P_NSG;
            end
            default: if (e == WT) nxt = m_after;
         endcase
         m_ticks = (nxt != m_ph) ? 0 : e;
      end
      m_ack = (nxt == P_PED) && !was_ped;
      if (m_ack) m_pend = 1'b0;
      else if (!was_ped && ped_req && PE) m_pend = 1'b1;
      m_ph = nxt;
      m_k++;
   endtask

   // One clk: apply inputs at negedge, step model, compare at following negedge.
   task automatic cycle(input bit nc, input bit ec, input bit pr);
      ns_car  = nc;
      ew_car  = ec;
      ped_req = pr;
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_eq("lamps", lamps, exp_lamps(m_ph));
      check_eq("tick", tick, ((m_k % TD) == TD - 1));
      check_eq("ped_ack", ped_ack, m_ack);
      check_eq("invariant", inv_ok(lamps), 1);
   endtask

   task automatic apply_reset();
      rst_n   = 1'b0;
      ns_car  = 1'b0;
      ew_car  = 1'b0;
      ped_req = 1'b0;
      #1;
      check_eq("rst_lamps", lamps, 7'b100_001_0);
      check_eq("rst_tick", tick, 0);
      check_eq("rst_ack", ped_ack, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      m_ph    = P_NSG;
      m_k     = 0;
      m_ticks = 0;
      m_pend  = 1'b0;
      m_ack   = 1'b0;
      m_after = P_NSG;
   endtask

   initial begin
      int first, n_walk, n_ack;
      bit nc, ec;
      rst_n   = 1'b0;
      ns_car  = 1'b0;
      ew_car  = 1'b0;
      ped_req = 1'b0;
      @(negedge clk);

      // Idle after reset: NS rests green.
      apply_reset();
      for (int i = 0; i < 200; i++) cycle(1'b0, 1'b0, 1'b0);
      check_eq("idle_rest", lamps, 7'b100_001_0);

      // Cross demand: EW green reached after 12 + 8 + 4 clks.
      apply_reset();
      first = -1;
      for (int i = 0; i < 80; i++) begin
         cycle(1'b0, 1'b1, 1'b0);
         if (first < 0 && ew_g) first = m_k;
      end
      check_eq("ew_g_start", first, 24);
      check_eq("ew_rest", lamps, 7'b001_100_0);

      // Contention: both approaches loaded.
      apply_reset();
      first = -1;
      for (int i = 0; i < 200; i++) begin
         cycle(1'b1, 1'b1, 1'b0);
         if (first < 0 && ew_g) first = m_k;
      end
      check_eq("contend_ew_start", first, 24 + 8 + 4);

      // Pedestrian request pulse at clk 2.
      apply_reset();
      first  = -1;
      n_walk = 0;
      for (int i = 0; i < 80; i++) begin
         cycle(1'b0, 1'b0, i == 2);
         if (first < 0 && ped_ack) first = m_k;
         if (walk) n_walk++;
      end
      check_eq("ped_ack_at", first, PE ? 24 : -1);
      check_eq("walk_clks", n_walk, PE ? 16 : 0);
      check_eq("ped_end_lamps", lamps, PE ? 7'b001_100_0 : 7'b100_001_0);

      // Reset in the middle of the walk phase.
      apply_reset();
      for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, i == 2);
      apply_reset();
      n_ack = 0;
      for (int i = 0; i < 60; i++) begin
         cycle(1'b0, 1'b0, 1'b0);
         if (ped_ack) n_ack++;
      end
      check_eq("ack_after_rst", n_ack, 0);

      // Random traffic with occasional button presses.
      apply_reset();
      nc = 1'b0;
      ec = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(15) == 0) nc = ~nc;
         if ($urandom_range(15) == 0) ec = ~ec;
         cycle(nc, ec, $urandom_range(39) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
